lc3_memaccess_stage: RTL and testbench
======================================

# lc3_memaccess_stage

Sequential MemAccess stage of the LC3 pipeline: the receiving end of the memaccess_in signal set (m_addr, m_data, m_control, mem_state, dmem_dout). It accepts one load/store request at a time, runs the data-memory access sequence (including the extra pointer fetch for LDI/STI), handshakes with a variable-latency data memory, and returns load data on memout. It sits between the Execute/controller outputs and the data memory.

## Interface
- TIMEOUT_CYCLES, 16: consecutive un-acked dmem_req cycles before abort. Used only with the timeout feature; legal range 2..255.
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low.
- mem_req, in, 1: request strobe, sampled only in IDLE.
- mem_we, in, 1: 1 = store (ST/STR/STI), 0 = load (LD/LDR/LDI).
- m_control, in, 1: 1 = indirect (LDI/STI), 0 = direct.
- m_addr, in, 16: effective or pointer address.
- m_data, in, 16: store data.
- dmem_req, out, 1: memory access request, held until dmem_ack.
- dmem_rd, out, 1: 1 = read, 0 = write.
- dmem_addr, out, 16: memory address.
- dmem_din, out, 16: memory write data.
- dmem_ack, in, 1: memory completion; read data valid on dmem_dout in the same cycle.
- dmem_dout, in, 16: memory read data.
- mem_state, out, 2: current phase: 00 = indirect pointer read, 01 = read, 10 = write, 11 = idle.
- memout, out, 16: last load result.
- mem_busy, out, 1: high in every non-IDLE state.
- mem_done, out, 1: one-cycle completion pulse.
- mem_err, out, 1: qualifies mem_done; 1 = aborted access.

## Operation
- States: IDLE (mem_state=11), IND (00), RD (01), WR (10). State is registered; dmem_req, dmem_rd, dmem_addr, dmem_din, and mem_state are all register outputs.
- IDLE with mem_req=1: capture m_addr into addr_q, m_data into data_q, mem_we, and m_control. Next state is IND if m_control=1, else WR if mem_we=1, else RD.
- mem_req is ignored outside IDLE. mem_busy=1 signals the upstream stage to stall.
- dmem_req=1 in IND, RD, and WR. dmem_rd=0 only in WR. dmem_addr=addr_q and dmem_din=data_q. All are stable while waiting for dmem_ack.
- IND with dmem_ack: addr_q <= dmem_dout, then go to WR (store) or RD (load). dmem_req stays high across the transition.
- RD with dmem_ack: memout <= dmem_dout, mem_done=1, go to IDLE.
- WR with dmem_ack: mem_done=1, go to IDLE. memout is unchanged.
- dmem_ack in IDLE is ignored.
- memout holds its value until the next successful load.

## Timing
- Reset values: state=IDLE, mem_state=11, dmem_req=0, dmem_rd=1, dmem_addr=0, dmem_din=0, memout=0, mem_busy=0, mem_done=0, mem_err=0, addr_q=0, data_q=0.
- A request sampled at cycle 0 drives dmem_req=1 at cycle 1.
- Direct access with ack at cycle 1: mem_done and memout are valid at cycle 2, and dmem_req=0 at cycle 2.
- Indirect access with zero-wait ack: first ack at cycle 1, second access with the new address at cycle 2, ack at cycle 2, mem_done at cycle 3.
- Each memory wait cycle adds exactly one cycle of latency.
- mem_done is high in the first IDLE cycle. A mem_req in that same cycle is accepted (back-to-back throughput of 2 cycles per direct access).
- Reset asserted mid-access: all outputs go to reset values immediately. There is no mem_done for the aborted access, and the memory must drop any outstanding request.

## Configuration
- MEMACCESS_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on every state entry and on dmem_ack, and increments each cycle dmem_req=1 without ack.
  - When it reaches TIMEOUT_CYCLES without ack: go to IDLE, pulse mem_done=1 with mem_err=1 in the next cycle, and leave memout unchanged.
  - An ack in the same cycle as the limit wins, giving a normal completion.
- MEMACCESS_TIMEOUT_EN undefined: no counter; the block waits indefinitely for ack; mem_err is tied to 0.

## Test plan
- Direct load: mem_req with mem_we=0, m_control=0, m_addr=0x3000, ack in the same cycle with dmem_dout=0xBEEF -> dmem_addr=0x3000 and dmem_rd=1 at cycle 1; memout=0xBEEF and mem_done=1 at cycle 2; mem_state sequence 11,01,11.
- Direct store with 3 wait cycles: m_addr=0x4010, m_data=0x1234 -> dmem_rd=0 and addr/din stable for 4 cycles; mem_done after the ack; memout unchanged.
- LDI: m_addr=0x3005, first dout=0x5000, second dout=0x00AA -> second dmem_addr=0x5000; memout=0x00AA; mem_state 11,00,01,11.
- STI: pointer read returns 0x6000, m_data=0xCAFE -> write to 0x6000 with dmem_din=0xCAFE and dmem_rd=0 in the second phase.
- Reset mid-RD (dmem_req high, no ack) -> immediately dmem_req=0, mem_state=11, memout=0, no mem_done; a new request is accepted after reset release.
- With MEMACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never arrives -> mem_done=1 and mem_err=1 five cycles after request acceptance; memout retains its prior value.

Source files
------------

// File: rtl/lc3_memaccess_stage.sv
// lc3_memaccess_stage: sequential MemAccess stage of the LC3 pipeline.
//
// Accepts one load/store request at a time from the Execute/controller side and
// runs the data-memory access sequence against a variable-latency memory. For
// LDI/STI it first reads a pointer, then performs the real access at the
// pointer's address. Load data is returned on memout.
//
// Optional feature: define MEMACCESS_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES consecutive un-acked request cycles (reported via mem_err).
// Without it the stage waits indefinitely and mem_err is tied low.
//
// Ports:
//   clock, reset      - clock (rising edge), asynchronous active-low reset
//   mem_req           - request strobe, sampled only in IDLE
//   mem_we            - 1 = store, 0 = load
//   m_control         - 1 = indirect (LDI/STI), 0 = direct
//   m_addr, m_data    - effective/pointer address, store data
//   dmem_req/rd       - memory request (held until ack), 1 = read / 0 = write
//   dmem_addr/din     - memory address and write data
//   dmem_ack/dout     - memory completion and read data (same cycle)
//   mem_state         - 00 = pointer read, 01 = read, 10 = write, 11 = idle
//   memout            - last load result
//   mem_busy          - high in every non-IDLE state (upstream stall)
//   mem_done          - one-cycle completion pulse
//   mem_err           - qualifies mem_done: 1 = aborted access
module lc3_memaccess_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        m_control,
  input  logic [15:0] m_addr,
  input  logic [15:0] m_data,
  output logic        dmem_req,
  output logic        dmem_rd,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_din,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_dout,
  output logic [1:0]  mem_state,
  output logic [15:0] memout,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        mem_err
);

  // Encodings match the externally visible mem_state values.
  typedef enum logic [1:0] {
    StInd  = 2'b00,
    StRd   = 2'b01,
    StWr   = 2'b10,
    StIdle = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic [15:0] memout_q, memout_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        req_q, rd_q;

`ifdef MEMACCESS_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       timeout;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    memout_d = memout_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          addr_d = m_addr;
          data_d = m_data;
          we_d   = mem_we;
          if (m_control)   state_d = StInd;
          else if (mem_we) state_d = StWr;
          else             state_d = StRd;
        end
      end
      StInd: begin
        // Pointer fetched: it becomes the address of the real access.
        if (dmem_ack) begin
          addr_d  = dmem_dout;
          state_d = we_q ? StWr : StRd;
        end
      end
      StRd: begin
        if (dmem_ack) begin
          memout_d = dmem_dout;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      StWr: begin
        if (dmem_ack) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MEMACCESS_TIMEOUT_EN
    // An ack in the limit cycle takes precedence, so timeout requires !dmem_ack.
    timeout = (state_q != StIdle) && !dmem_ack &&
              (wait_q == 8'(TIMEOUT_CYCLES - 1));
    if (timeout) begin
      state_d = StIdle;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
    if ((state_d != state_q) || dmem_ack) wait_d = 8'd0;
    else if (state_q != StIdle)           wait_d = wait_q + 8'd1;
    else                                  wait_d = wait_q;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      we_q     <= 1'b0;
      memout_q <= 16'h0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      rd_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      memout_q <= memout_d;
      done_q   <= done_d;
      err_q    <= err_d;
      // Request/direction registered from next state so they stay glitch-free
      // and remain high across the IND -> RD/WR transition.
      req_q    <= (state_d != StIdle);
      rd_q     <= (state_d != StWr);
    end
  end

`ifdef MEMACCESS_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wait_q <= 8'd0;
    else        wait_q <= wait_d;
  end
`endif

  assign dmem_req  = req_q;
  assign dmem_rd   = rd_q;
  assign dmem_addr = addr_q;
  assign dmem_din  = data_q;
  assign mem_state = state_q;
  assign memout    = memout_q;
  assign mem_busy  = (state_q != StIdle);
  assign mem_done  = done_q;
`ifdef MEMACCESS_TIMEOUT_EN
  assign mem_err   = err_q;
`else
  assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_memaccess_stage.sv
module tb_lc3_memaccess_stage;

`ifdef MEMACCESS_TIMEOUT_EN
  localparam int unsigned To = 4;
`else
  localparam int unsigned To = 16;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic        m_control = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [15:0] m_data = 16'h0;
  logic        dmem_req;
  logic        dmem_rd;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_dout = 16'h0;
  logic [1:0]  mem_state;
  logic [15:0] memout;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  lc3_memaccess_stage #(.TIMEOUT_CYCLES(To)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .m_control (m_control),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .dmem_req  (dmem_req),
    .dmem_rd   (dmem_rd),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_ack  (dmem_ack),
    .dmem_dout (dmem_dout),
    .mem_state (mem_state),
    .memout    (memout),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mem_err   (mem_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic we, input logic ind, input logic [15:0] a,
                         input logic [15:0] d);
    mem_req = 1'b1; mem_we = we; m_control = ind; m_addr = a; m_data = d;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_state", 16'(mem_state), 16'h3);
    chk("rst_req", 16'(dmem_req), 16'h0);
    chk("rst_rd", 16'(dmem_rd), 16'h1);
    chk("rst_addr", dmem_addr, 16'h0);
    chk("rst_din", dmem_din, 16'h0);
    chk("rst_memout", memout, 16'h0);
    chk("rst_busy", 16'(mem_busy), 16'h0);
    chk("rst_done", 16'(mem_done), 16'h0);
    chk("rst_err", 16'(mem_err), 16'h0);
    reset = 1'b1;
    tick();

    // Direct load, zero wait
    request(1'b0, 1'b0, 16'h3000, 16'h0);
    tick();
    mem_req = 1'b0;
    chk("ld_state1", 16'(mem_state), 16'h1);
    chk("ld_req1", 16'(dmem_req), 16'h1);
    chk("ld_rd1", 16'(dmem_rd), 16'h1);
    chk("ld_addr1", dmem_addr, 16'h3000);
    chk("ld_busy1", 16'(mem_busy), 16'h1);
    dmem_ack = 1'b1; dmem_dout = 16'hBEEF;
    tick();
    dmem_ack = 1'b0;
    chk("ld_done2", 16'(mem_done), 16'h1);
    chk("ld_err2", 16'(mem_err), 16'h0);
    chk("ld_memout2", memout, 16'hBEEF);
    chk("ld_req2", 16'(dmem_req), 16'h0);
    chk("ld_state2", 16'(mem_state), 16'h3);
    tick();
    chk("ld_done3", 16'(mem_done), 16'h0);

    // Direct store with 3 wait cycles
    request(1'b1, 1'b0, 16'h4010, 16'h1234);
    tick();
    mem_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_state", 16'(mem_state), 16'h2);
      chk("st_req", 16'(dmem_req), 16'h1);
      chk("st_rd", 16'(dmem_rd), 16'h0);
      chk("st_addr", dmem_addr, 16'h4010);
      chk("st_din", dmem_din, 16'h1234);
      chk("st_nodone", 16'(mem_done), 16'h0);
      if (i == 3) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    chk("st_done", 16'(mem_done), 16'h1);
    chk("st_memout", memout, 16'hBEEF);
    chk("st_req_off", 16'(dmem_req), 16'h0);
    tick();

    // LDI
    request(1'b0, 1'b1, 16'h3005, 16'h0);
    tick();
    mem_req = 1'b0;
    chk("ldi_state1", 16'(mem_state), 16'h0);
    chk("ldi_addr1", dmem_addr, 16'h3005);
    chk("ldi_rd1", 16'(dmem_rd), 16'h1);
    dmem_ack = 1'b1; dmem_dout = 16'h5000;
    tick();
    chk("ldi_state2", 16'(mem_state), 16'h1);
    chk("ldi_addr2", dmem_addr, 16'h5000);
    chk("ldi_req2", 16'(dmem_req), 16'h1);
    chk("ldi_nodone2", 16'(mem_done), 16'h0);
    dmem_dout = 16'h00AA;
    tick();
    dmem_ack = 1'b0;
    chk("ldi_done3", 16'(mem_done), 16'h1);
    chk("ldi_memout3", memout, 16'h00AA);
    chk("ldi_state3", 16'(mem_state), 16'h3);
    tick();

    // STI, then back-to-back direct load in the done cycle
    request(1'b1, 1'b1, 16'h3010, 16'hCAFE);
    tick();
    mem_req = 1'b0;
    chk("sti_state1", 16'(mem_state), 16'h0);
    chk("sti_rd1", 16'(dmem_rd), 16'h1);
    dmem_ack = 1'b1; dmem_dout = 16'h6000;
    tick();
    chk("sti_state2", 16'(mem_state), 16'h2);
    chk("sti_addr2", dmem_addr, 16'h6000);
    chk("sti_din2", dmem_din, 16'hCAFE);
    chk("sti_rd2", 16'(dmem_rd), 16'h0);
    tick();
    dmem_ack = 1'b0;
    chk("sti_done3", 16'(mem_done), 16'h1);
    chk("sti_memout3", memout, 16'h00AA);
    request(1'b0, 1'b0, 16'h7000, 16'h0);
    tick();
    mem_req = 1'b0;
    chk("b2b_state", 16'(mem_state), 16'h1);
    chk("b2b_addr", dmem_addr, 16'h7000);
    dmem_ack = 1'b1; dmem_dout = 16'h1111;
    tick();
    chk("b2b_done", 16'(mem_done), 16'h1);
    chk("b2b_memout", memout, 16'h1111);

    // Ack while idle is ignored
    dmem_dout = 16'hFFFF;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_memout", memout, 16'h1111);
    chk("idle_ack_done", 16'(mem_done), 16'h0);
    chk("idle_ack_state", 16'(mem_state), 16'h3);

    // Reset mid-RD
    request(1'b0, 1'b0, 16'h8000, 16'h0);
    tick();
    mem_req = 1'b0;
    chk("mid_req", 16'(dmem_req), 16'h1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_req", 16'(dmem_req), 16'h0);
    chk("rstmid_state", 16'(mem_state), 16'h3);
    chk("rstmid_memout", memout, 16'h0);
    chk("rstmid_done", 16'(mem_done), 16'h0);
    tick();
    chk("rstmid_done2", 16'(mem_done), 16'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_done", 16'(mem_done), 16'h0);
    request(1'b0, 1'b0, 16'h9000, 16'h0);
    tick();
    mem_req = 1'b0;
    chk("post_rst_addr", dmem_addr, 16'h9000);
    dmem_ack = 1'b1; dmem_dout = 16'h0042;
    tick();
    dmem_ack = 1'b0;
    chk("post_rst_done2", 16'(mem_done), 16'h1);
    chk("post_rst_memout", memout, 16'h0042);
    tick();

    // Long wait: aborts with TIMEOUT_CYCLES=4, otherwise keeps waiting
    request(1'b0, 1'b0, 16'hA000, 16'h0);
    tick();
    mem_req = 1'b0;
`ifdef MEMACCESS_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      chk("to_nodone", 16'(mem_done), 16'h0);
      chk("to_req", 16'(dmem_req), 16'h1);
      tick();
    end
    chk("to_done", 16'(mem_done), 16'h1);
    chk("to_err", 16'(mem_err), 16'h1);
    chk("to_memout", memout, 16'h0042);
    chk("to_state", 16'(mem_state), 16'h3);
    tick();
    chk("to_done_off", 16'(mem_done), 16'h0);
    chk("to_err_off", 16'(mem_err), 16'h0);
`else
    for (int i = 1; i <= 24; i++) tick();
    chk("wait_req", 16'(dmem_req), 16'h1);
    chk("wait_state", 16'(mem_state), 16'h1);
    chk("wait_nodone", 16'(mem_done), 16'h0);
    dmem_ack = 1'b1; dmem_dout = 16'h5A5A;
    tick();
    dmem_ack = 1'b0;
    chk("wait_done", 16'(mem_done), 16'h1);
    chk("wait_err", 16'(mem_err), 16'h0);
    chk("wait_memout", memout, 16'h5A5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
